// File: rtl/regfile_pkg.sv
// regfile_pkg: shared operand width and register index constants for decoder, ALU and register file
package regfile_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/regfile.sv
// regfile: 32 x WIDTH register file, two registered read ports, one write port; x0 hardwired to 0.
// Ports: clk, reset (sync, active-high), rs1_addr/rs2_addr read addresses, rd_en (low holds outputs),
//        we/waddr/wdata write port, rs1_data/rs2_data registered read data.
// Macro REGFILE_BYPASS_EN: a same-cycle write to a read address forwards wdata to that port.
module regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rd_en,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rs1_data,
  output logic [WIDTH-1:0]      rs2_data
);
  logic [WIDTH-1:0] mem [NUM_REGS];
  logic [WIDTH-1:0] rd1, rd2;
  logic             wr;
  assign wr = we && waddr != REG_ZERO;
`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd1 = rs1_addr == REG_ZERO ? '0 : wr && waddr == rs1_addr ? wdata : mem[rs1_addr];
    rd2 = rs2_addr == REG_ZERO ? '0 : wr && waddr == rs2_addr ? wdata : mem[rs2_addr];
  end
`else
  always_comb begin
    rd1 = rs1_addr == REG_ZERO ? '0 : mem[rs1_addr];
    rd2 = rs2_addr == REG_ZERO ? '0 : mem[rs2_addr];
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      rs1_data <= '0;
      rs2_data <= '0;
    end else begin
      if (wr) mem[waddr] <= wdata;
      if (rd_en) begin
        rs1_data <= rd1;
        rs2_data <= rd2;
      end
    end
  end
endmodule
